// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / RAM arbitration controller.
package pipe_hazard_ctrl_pkg;

    // Who currently owns the single shared RAM.
    typedef enum logic {
        S_FETCH = 1'b0,
        S_MEM   = 1'b1
    } state_e;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    localparam int REG_ADDR_W_DEF = 3;
    localparam int MEM_WAIT_DEF   = 2;

    // Access counter width; a single-cycle RAM still gets a 1-bit counter that stays at 0.
    function automatic int cnt_width(input int mem_wait);
        return (mem_wait > 1) ? $clog2(mem_wait) : 1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: hazard inputs from ID/EX/MEM and
// the enables/RAM controls it hands back. The pipeline is the master, the controller the slave.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
);
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_branch_taken;
    logic                  mem_req;
    logic                  mem_we;

    logic pc_write;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_bubble;
    logic mem_stall;
    logic ram_owner;
    logic ram_ce;
    logic ram_we;
    logic inst_valid;
    logic mem_ack;

    modport master (
        output id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               ex_mem_read, ex_rd_addr, ex_branch_taken, mem_req, mem_we,
        input  pc_write, if_id_stall, if_id_flush, id_ex_bubble, mem_stall,
               ram_owner, ram_ce, ram_we, inst_valid, mem_ack
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               ex_mem_read, ex_rd_addr, ex_branch_taken, mem_req, mem_we,
        output pc_write, if_id_stall, if_id_flush, id_ex_bubble, mem_stall,
               ram_owner, ram_ce, ram_we, inst_valid, mem_ack
    );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use detector: the instruction in ID reads a register that the load in EX
// has not yet written. Purely combinational.
module load_use_detect #(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
    input  logic                  id_rs_used_i,
    input  logic                  id_rt_used_i,
    output logic                  load_use_o
);
    // No hardwired-zero register, so r0 is a real dependency like any other.
    always_comb begin
        load_use_o = ex_mem_read_i &
                     ((id_rs_used_i & (id_rs_addr_i == ex_rd_addr_i)) |
                      (id_rt_used_i & (id_rt_addr_i == ex_rd_addr_i)));
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-of-pipeline sequencer: shares one RAM between fetch and the MEM stage and
// derives PC / IF/ID / ID/EX enables from memory waits, taken branches and load-use hazards.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_WAIT   = MEM_WAIT_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int                CNT_W    = cnt_width(MEM_WAIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_WAIT - 1);

    state_e           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use;
    logic done;
    logic in_fetch;
    logic mem_ack_c;
    logic mem_stall_c;
    logic pc_write_c;
    logic if_id_stall_c;
    logic if_id_flush_c;
    logic id_ex_bubble_c;
    logic inst_valid_c;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_lud (
        .ex_mem_read_i (hz.ex_mem_read),
        .ex_rd_addr_i  (hz.ex_rd_addr),
        .id_rs_addr_i  (hz.id_rs_addr),
        .id_rt_addr_i  (hz.id_rt_addr),
        .id_rs_used_i  (hz.id_rs_used),
        .id_rt_used_i  (hz.id_rt_used),
        .load_use_o    (load_use)
    );

    // Access timing, next state and the hazard priority chain (first match wins).
    always_comb begin
        in_fetch       = (st_q == S_FETCH);
        done           = (cnt_q == CNT_LAST);
        mem_ack_c      = ~in_fetch & done;
        mem_stall_c    = hz.mem_req & ~mem_ack_c;

        st_d           = st_q;
        cnt_d          = done ? '0 : cnt_q + CNT_W'(1);
        pc_write_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        inst_valid_c   = 1'b0;

        // A fetch that completes while MEM is waiting is thrown away; MEM takes the RAM next.
        if (in_fetch && done && hz.mem_req) begin
            st_d = S_MEM;
        end else if (!in_fetch && done) begin
            st_d = S_FETCH;
        end

        if (rst) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
        end else if (mem_stall_c) begin
            if_id_stall_c  = 1'b1;
        end else if (hz.ex_branch_taken) begin
            pc_write_c     = 1'b1;
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            // Abort the wrong-path fetch and start the target fetch from scratch.
            if (in_fetch) begin
                cnt_d = '0;
            end
        end else if (load_use) begin
            if_id_stall_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
        end else if (!(in_fetch && done)) begin
            if_id_flush_c  = 1'b1;
        end else begin
            pc_write_c     = 1'b1;
            inst_valid_c   = 1'b1;
        end
    end

    // State and access counter; reset returns the RAM to fetch immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= S_FETCH;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    assign hz.pc_write     = pc_write_c;
    assign hz.if_id_stall  = if_id_stall_c;
    assign hz.if_id_flush  = if_id_flush_c;
    assign hz.id_ex_bubble = id_ex_bubble_c;
    assign hz.inst_valid   = inst_valid_c;
    assign hz.mem_stall    = mem_stall_c & ~rst;
    assign hz.mem_ack      = mem_ack_c & ~rst;
    assign hz.ram_owner    = (st_q == S_MEM) ? OWNER_MEM : OWNER_IF;
    assign hz.ram_ce       = ~rst;
    assign hz.ram_we       = hz.mem_we & (st_q == S_MEM);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model of the pipeline front.
module tb_pipe_hazard_ctrl;
    localparam int MEM_WAIT = 2;
    localparam int RAW      = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_ADDR_W(RAW)) hz ();

    pipe_hazard_ctrl #(
        .MEM_WAIT   (MEM_WAIT),
        .REG_ADDR_W (RAW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    // Output vector order: pc_write, if_id_stall, if_id_flush, id_ex_bubble, mem_stall,
    // ram_owner, ram_ce, ram_we, inst_valid, mem_ack
    function automatic logic [9:0] outs();
        return {hz.pc_write, hz.if_id_stall, hz.if_id_flush, hz.id_ex_bubble, hz.mem_stall,
                hz.ram_owner, hz.ram_ce, hz.ram_we, hz.inst_valid, hz.mem_ack};
    endfunction

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b (pw,stl,fl,bub,mstl,own,ce,we,iv,ack) t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [9:0] exp);
        @(negedge clk);
        chk(nm, outs(), exp);
    endtask

    task automatic clear_inputs();
        hz.id_rs_addr      = '0;
        hz.id_rt_addr      = '0;
        hz.id_rs_used      = 1'b0;
        hz.id_rt_used      = 1'b0;
        hz.ex_mem_read     = 1'b0;
        hz.ex_rd_addr      = '0;
        hz.ex_branch_taken = 1'b0;
        hz.mem_req         = 1'b0;
        hz.mem_we          = 1'b0;
    endtask

    // Behavioural model: which client holds the RAM and how many cycles of the current
    // access have already elapsed; outputs follow from the hazard priority rules.
    initial begin
        bit           in_mem;
        int           age;
        bit           fin, ack, mstl, lu, br;
        bit           pw, stl, fl, bub, iv;
        logic [9:0]   exp;
        in_mem = 0;
        age    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp    = 10'b0011000000;
                in_mem = 0;
                age    = 0;
            end else begin
                fin  = (age == MEM_WAIT - 1);
                ack  = in_mem && fin;
                mstl = hz.mem_req && !ack;
                br   = hz.ex_branch_taken;
                lu   = hz.ex_mem_read &&
                       ((hz.id_rs_used && hz.id_rs_addr == hz.ex_rd_addr) ||
                        (hz.id_rt_used && hz.id_rt_addr == hz.ex_rd_addr));
                {pw, stl, fl, bub, iv} = '0;
                if (mstl)                 stl = 1;
                else if (br)              begin pw = 1; fl = 1; bub = 1; end
                else if (lu)              begin stl = 1; bub = 1; end
                else if (in_mem || !fin)  fl = 1;
                else                      begin pw = 1; iv = 1; end
                exp = {pw, stl, fl, bub, mstl, in_mem, 1'b1, hz.mem_we && in_mem, iv, ack};
                if (in_mem) begin
                    if (fin) begin in_mem = 0; age = 0; end
                    else age++;
                end else if (!mstl && br) begin
                    age = 0;
                end else if (fin) begin
                    age    = 0;
                    in_mem = hz.mem_req;
                end else begin
                    age++;
                end
            end
            chk("model", outs(), exp);
        end
    end

    initial begin
        bit ack_seen;
        bit req_active;
        rst = 1'b1;
        clear_inputs();
        step();
        lit("reset_hold", 10'b0011000000);
        step();
        rst = 1'b0;
        lit("rel_c0", 10'b0010001000);
        step(); lit("rel_c1", 10'b1000001010);
        step(); lit("rel_c2", 10'b0010001000);
        step(); lit("rel_c3", 10'b1000001010);

        step();
        hz.mem_req = 1'b1;
        hz.mem_we  = 1'b1;
        lit("mreq_c0", 10'b0100101000);
        step(); lit("mreq_c1", 10'b0100101000);
        step(); lit("mreq_mem0", 10'b0100111100);
        step(); lit("mreq_ack", 10'b0010011101);

        step();
        hz.mem_req     = 1'b0;
        hz.mem_we      = 1'b0;
        hz.ex_mem_read = 1'b1;
        hz.ex_rd_addr  = 3'd3;
        hz.id_rs_addr  = 3'd3;
        hz.id_rs_used  = 1'b1;
        hz.id_rt_addr  = 3'd5;
        lit("load_use", 10'b0101001000);
        step();
        hz.ex_mem_read = 1'b0;
        lit("lu_after", 10'b1000001010);
        step(); lit("pre_br", 10'b0010001000);
        step();
        hz.ex_branch_taken = 1'b1;
        lit("branch_c1", 10'b1011001000);
        step();
        hz.ex_branch_taken = 1'b0;
        lit("br_restart", 10'b0010001000);
        step(); lit("br_fetch", 10'b1000001010);

        step();
        hz.ex_branch_taken = 1'b1;
        hz.ex_mem_read     = 1'b1;
        hz.mem_req         = 1'b1;
        lit("all_hazards", 10'b0100101000);
        step();
        hz.ex_branch_taken = 1'b0;
        hz.ex_mem_read     = 1'b0;
        lit("all_c1", 10'b0100101000);
        step(); lit("all_mem0", 10'b0100111000);
        step();
        #2;
        rst = 1'b1;
        lit("rst_in_mem", 10'b0011000000);
        step();
        step();
        rst = 1'b0;
        clear_inputs();
        lit("rst_rel", 10'b0010001000);

        req_active = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ack_seen = hz.mem_ack;
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 99) == 0);
            if (rst) begin
                req_active = 0;
                hz.mem_req = 1'b0;
            end else if (!(req_active && !ack_seen)) begin
                req_active = ($urandom_range(0, 4) == 0);
                hz.mem_req = req_active;
                hz.mem_we  = $urandom_range(0, 1);
            end
            hz.ex_branch_taken = ($urandom_range(0, 5) == 0);
            hz.ex_mem_read     = ($urandom_range(0, 2) == 0);
            hz.ex_rd_addr      = RAW'($urandom_range(0, 7));
            hz.id_rs_addr      = $urandom_range(0, 1) ? hz.ex_rd_addr : RAW'($urandom_range(0, 7));
            hz.id_rt_addr      = RAW'($urandom_range(0, 7));
            hz.id_rs_used      = $urandom_range(0, 1);
            hz.id_rt_used      = $urandom_range(0, 1);
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
